// File: rtl/mdu_scheduler_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings, default
// latencies and the sequencer state type.
package mdu_scheduler_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } md_state_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   function automatic logic is_arith_op(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_known_op(input logic [3:0] op);
      return (op != MD_NONE) && (op <= MD_MFLO);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply / divide datapath; result is {HI, LO}.
module mdu_arith
   import mdu_scheduler_pkg::*;
(
   input  logic [3:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_zero
);

   logic [63:0] prod;
   logic [31:0] mag_a, mag_b, quo, rem;
   logic        neg_a, neg_b;

   always_comb begin
      prod     = '0;
      mag_a    = a;
      mag_b    = b;
      quo      = '0;
      rem      = '0;
      neg_a    = 1'b0;
      neg_b    = 1'b0;
      div_zero = 1'b0;
      case (md_op)
         MD_MULT:  prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         MD_MULTU: prod = {32'b0, a} * {32'b0, b};
         MD_DIV, MD_DIVU: begin
            // Divide magnitudes and fix signs afterwards so that the
            // 0x80000000 / -1 case needs no special path.
            neg_a    = (md_op == MD_DIV) && a[31];
            neg_b    = (md_op == MD_DIV) && b[31];
            mag_a    = neg_a ? -a : a;
            mag_b    = neg_b ? -b : b;
            div_zero = (b == '0);
            if (!div_zero) begin
               quo = mag_a / mag_b;
               rem = mag_a % mag_b;
            end
            if (neg_a ^ neg_b) quo = -quo;
            if (neg_a)         rem = -rem;
            prod = {rem, quo};
         end
         default: prod = '0;
      endcase
      res_hi = prod[63:32];
      res_lo = prod[31:0];
   end

endmodule

// File: rtl/mdu_scheduler.sv
// E-stage multiply/divide unit: fixed-latency sequencing, HI/LO ownership,
// pipeline stall and mfhi/mflo read port.
module mdu_scheduler
   import mdu_scheduler_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        req,
   output logic        start,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] md_rdata,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   md_state_e      state;
   logic [CW-1:0]  cnt;
   logic [31:0]    pend_hi, pend_lo;
   logic           pend_dz;
   logic [31:0]    res_hi, res_lo;
   logic           div_zero;
   logic           idle_ok;

   mdu_arith u_arith (
      .md_op    (md_op),
      .a        (a),
      .b        (b),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .div_zero (div_zero)
   );

   assign idle_ok  = (state == S_IDLE) && !req;
   assign start    = is_arith_op(md_op) && idle_ok;
   // The accepting instruction itself is never stalled; only busy stalls.
   assign md_stall = is_known_op(md_op) && busy;

   always_comb begin
      md_rdata = '0;
      if (md_op == MD_MFHI)      md_rdata = hi;
      else if (md_op == MD_MFLO) md_rdata = lo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pend_hi <= res_hi;
                  pend_lo <= res_lo;
                  pend_dz <= div_zero;
                  cnt     <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                             CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  state   <= S_RUN;
                  busy    <= 1'b1;
               end else if (idle_ok && (md_op == MD_MTHI)) begin
                  hi <= a;
               end else if (idle_ok && (md_op == MD_MTLO)) begin
                  lo <= a;
               end
            end
            S_RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  if (!pend_dz) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Randomized self-checking bench for mdu_scheduler against a cycle-count
// reference model that uses plain 64-bit arithmetic.
module tb_mdu_scheduler;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset, req;
   logic [3:0]  md_op;
   logic [31:0] a, b;
   logic        start, busy, md_stall;
   logic [31:0] md_rdata, hi, lo;

   mdu_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk      (clk),
      .reset    (reset),
      .md_op    (md_op),
      .a        (a),
      .b        (b),
      .req      (req),
      .start    (start),
      .busy     (busy),
      .md_stall (md_stall),
      .md_rdata (md_rdata),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: committed regs plus the cycle on which the in-flight op ends.
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   bit          m_pdz;
   int          m_run_end = -1;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic ref_arith(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] rh, output logic [31:0] rl, output bit dz);
      longint          sx, sy, p, q, r;
      longint unsigned ux, uy, up;
      sx = $signed(x);
      sy = $signed(y);
      ux = x;
      uy = y;
      rh = '0; rl = '0; dz = 1'b0;
      case (op)
         4'd1: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
         4'd2: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
         4'd3: begin
            if (y == 0) dz = 1'b1;
            else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
         end
         4'd4: begin
            if (y == 0) dz = 1'b1;
            else begin up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0]; end
         end
         default: ;
      endcase
   endtask

   task automatic step(input logic rst, input logic [3:0] op, input logic [31:0] ia,
                       input logic [31:0] ib, input logic ireq);
      bit          m_busy, is_ar, known, exp_start;
      logic [31:0] exp_rd, rh, rl;
      bit          dz;
      @(negedge clk);
      reset = rst; md_op = op; a = ia; b = ib; req = ireq;
      #1;
      m_busy    = (cyc <= m_run_end);
      is_ar     = (op >= 4'd1) && (op <= 4'd4);
      known     = (op >= 4'd1) && (op <= 4'd8);
      exp_start = is_ar && !m_busy && !ireq;
      exp_rd    = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
      check32("busy",     {31'b0, busy},     {31'b0, m_busy});
      check32("start",    {31'b0, start},    {31'b0, exp_start});
      check32("md_stall", {31'b0, md_stall}, {31'b0, known && m_busy});
      check32("md_rdata", md_rdata, exp_rd);
      check32("hi", hi, m_hi);
      check32("lo", lo, m_lo);
      @(posedge clk);
      if (rst) begin
         m_hi = '0; m_lo = '0; m_run_end = -1;
      end else if (m_busy) begin
         if ((cyc == m_run_end) && !m_pdz) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (exp_start) begin
         ref_arith(op, ia, ib, rh, rl, dz);
         m_phi = rh; m_plo = rl; m_pdz = dz;
         m_run_end = cyc + ((op <= 4'd2) ? MULT_N : DIV_N);
      end else if (!ireq && op == 4'd5) begin
         m_hi = ia;
      end else if (!ireq && op == 4'd6) begin
         m_lo = ia;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1; req = 1'b0; md_op = 4'd0; a = '0; b = '0;
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pdz = 1'b0;

      step(1'b1, 4'd0, 32'h0, 32'h0, 1'b0);
      step(1'b1, 4'd0, 32'h0, 32'h0, 1'b0);

      step(1'b0, 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle(MULT_N + 1);
      #1;
      check32("mult_hi", hi, 32'hFFFF_FFFF);
      check32("mult_lo", lo, 32'hFFFF_FFFE);

      step(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle(MULT_N + 1);
      #1;
      check32("multu_hi", hi, 32'h0000_0001);
      check32("multu_lo", lo, 32'hFFFF_FFFE);

      step(1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(DIV_N + 1);
      #1;
      check32("div_lo", lo, 32'hFFFF_FFFD);
      check32("div_hi", hi, 32'hFFFF_FFFF);

      step(1'b0, 4'd5, 32'h1234_5678, 32'h0, 1'b0);
      step(1'b0, 4'd6, 32'h1234_5678, 32'h0, 1'b0);
      step(1'b0, 4'd4, 32'd100, 32'd0, 1'b0);
      idle(DIV_N + 1);
      #1;
      check32("divz_hi", hi, 32'h1234_5678);
      check32("divz_lo", lo, 32'h1234_5678);

      // mfhi held in E while a mult is in flight
      step(1'b0, 4'd1, 32'd3, 32'd4, 1'b0);
      for (int i = 0; i < MULT_N + 1; i++) step(1'b0, 4'd7, 32'h0, 32'h0, 1'b0);
      #1;
      check32("mfhi_after", md_rdata, 32'h0);

      step(1'b0, 4'd3, 32'd50, 32'd7, 1'b1);
      step(1'b0, 4'd5, 32'd5, 32'h0, 1'b1);
      #1;
      check32("flush_busy", {31'b0, busy}, 32'h0);
      check32("flush_mthi", hi, 32'h0);

      step(1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(DIV_N + 1);
      #1;
      check32("ovf_lo", lo, 32'h8000_0000);
      check32("ovf_hi", hi, 32'h0);

      step(1'b0, 4'd5, 32'hAAAA_5555, 32'h0, 1'b0);
      step(1'b0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle(2);
      step(1'b1, 4'd0, 32'h0, 32'h0, 1'b0);
      #1;
      check32("rst_busy", {31'b0, busy}, 32'h0);
      check32("rst_hi", hi, 32'h0);
      check32("rst_lo", lo, 32'h0);
      idle(MULT_N + 1);
      #1;
      check32("rst_discard_lo", lo, 32'h0);

      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) == 0), 4'($urandom_range(0, 15)),
              rand_operand(), rand_operand(), ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
